// File: rtl/bsg_imul_pkg.sv
// Shared types for the iterative-multiplier dispatch front end: RV32M multiply
// opcodes, their decode into multiplier controls, and the dispatch FSM states.
package bsg_imul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } imul_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } imul_state_e;

    typedef struct packed {
        logic signed_a;
        logic signed_b;
        logic high;
    } imul_ctrl_s;

    // Map an RV32M multiply op onto the multiplier's operand-sign and
    // high-half selects.
    function automatic imul_ctrl_s imul_decode(input imul_op_e op);
        imul_ctrl_s c;
        c.signed_a = (op == MULH) || (op == MULHSU);
        c.signed_b = (op == MULH);
        c.high     = (op != MUL);
        return c;
    endfunction

endpackage

// File: rtl/bsg_imul_dispatch_fifo.sv
// Small request FIFO for the multiply dispatcher. Pointers carry one extra
// wrap bit so full/empty are unambiguous; depth must be a power of two.
// Enqueue while full is legal only together with a dequeue in the same cycle.
module bsg_imul_dispatch_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     enq_i,
    input  logic                     deq_i,
    input  logic [width_p-1:0]       data_i,
    output logic [width_p-1:0]       data_o,
    output logic                     full_o,
    output logic [$clog2(els_p):0]   count_o
);

    localparam int ptr_w_lp = $clog2(els_p);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp:0]   wptr_q, wptr_d;
    logic [ptr_w_lp:0]   rptr_q, rptr_d;

    // Pointer advance; the spare MSB distinguishes full from empty.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (enq_i) wptr_d = wptr_q + 1'b1;
        if (deq_i) rptr_d = rptr_q + 1'b1;
    end

    // Control state: pointers only, cleared by reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write; contents are meaningless until pointed to, so no reset.
    always_ff @(posedge clk_i) begin
        if (enq_i) mem_q[wptr_q[ptr_w_lp-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rptr_q[ptr_w_lp-1:0]];
    assign count_o = wptr_q - rptr_q;
    assign full_o  = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp]) &&
                     (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);

endmodule

// File: rtl/bsg_imul_dispatch.sv
// Dispatch front end for the iterative integer multiplier. Requests are queued,
// decoded and issued one at a time; each result returns with its tag through a
// one-entry output register, in request order.
// Optional feature: define BSG_IMUL_DISPATCH_ZERO_BYPASS_EN to answer ops with
// a zero operand directly (result 0) without occupying the multiplier.
module bsg_imul_dispatch
    import bsg_imul_pkg::*;
#(
    parameter int width_p     = 32,
    parameter int tag_width_p = 4,
    parameter int els_p       = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,

    input  logic                   v_i,
    output logic                   ready_and_o,
    input  logic [1:0]             op_i,
    input  logic [width_p-1:0]     opA_i,
    input  logic [width_p-1:0]     opB_i,
    input  logic [tag_width_p-1:0] tag_i,

    output logic                   v_o,
    output logic [width_p-1:0]     result_o,
    output logic [tag_width_p-1:0] tag_o,
    input  logic                   yumi_i,

    output logic                   mul_v_o,
    input  logic                   mul_ready_and_i,
    output logic [width_p-1:0]     mul_opA_o,
    output logic [width_p-1:0]     mul_opB_o,
    output logic                   mul_signed_opA_o,
    output logic                   mul_signed_opB_o,
    output logic                   mul_gets_high_part_o,
    input  logic                   mul_v_i,
    input  logic [width_p-1:0]     mul_result_i,
    output logic                   mul_yumi_o
);

    typedef struct packed {
        logic [1:0]             op;
        logic [width_p-1:0]     a;
        logic [width_p-1:0]     b;
        logic [tag_width_p-1:0] tag;
    } entry_s;

    localparam int entry_w_lp = $bits(entry_s);

    entry_s                  enq_entry, head;
    logic                    fifo_enq, fifo_deq, fifo_full, fifo_empty;
    logic [$clog2(els_p):0]  fifo_count;
    logic                    out_free;
    imul_ctrl_s              ctrl;

    imul_state_e             state_q, state_d;
    logic [tag_width_p-1:0]  tag_r_q, tag_r_d;
    logic                    out_v_q, out_v_d;
    logic [width_p-1:0]      out_result_q, out_result_d;
    logic [tag_width_p-1:0]  out_tag_q, out_tag_d;

`ifdef BSG_IMUL_DISPATCH_ZERO_BYPASS_EN
    logic                    head_zero;
    assign head_zero = (head.a == '0) || (head.b == '0);
`endif

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign ready_and_o = reset_n_i & (~fifo_full | fifo_deq);
    assign fifo_enq    = v_i & ready_and_o;
    assign fifo_empty  = (fifo_count == '0);
    assign enq_entry   = '{op: op_i, a: opA_i, b: opB_i, tag: tag_i};

    bsg_imul_dispatch_fifo #(
        .width_p (entry_w_lp),
        .els_p   (els_p)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enq_i     (fifo_enq),
        .deq_i     (fifo_deq),
        .data_i    (enq_entry),
        .data_o    (head),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    // Operands pass through untouched; only the controls are decoded.
    assign ctrl                 = imul_decode(imul_op_e'(head.op));
    assign mul_opA_o            = head.a;
    assign mul_opB_o            = head.b;
    assign mul_signed_opA_o     = ctrl.signed_a;
    assign mul_signed_opB_o     = ctrl.signed_b;
    assign mul_gets_high_part_o = ctrl.high;

    assign out_free = ~out_v_q | yumi_i;

    // Dispatch FSM: issue head, wait for the product, hand it to the output register.
    always_comb begin
        state_d      = state_q;
        tag_r_d      = tag_r_q;
        out_v_d      = out_v_q & ~yumi_i;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        fifo_deq     = 1'b0;
        mul_v_o      = 1'b0;
        mul_yumi_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty || fifo_enq) state_d = S_ISSUE;
            end
            S_ISSUE: begin
`ifdef BSG_IMUL_DISPATCH_ZERO_BYPASS_EN
                if (head_zero) begin
                    if (out_free) begin
                        fifo_deq     = 1'b1;
                        out_v_d      = 1'b1;
                        out_result_d = '0;
                        out_tag_d    = head.tag;
                        state_d      = ((fifo_count > 1) || fifo_enq) ? S_ISSUE : S_IDLE;
                    end
                end else
`endif
                begin
                    mul_v_o = 1'b1;
                    if (mul_ready_and_i) begin
                        fifo_deq = 1'b1;
                        tag_r_d  = head.tag;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                mul_yumi_o = mul_v_i & out_free;
                if (mul_yumi_o) begin
                    out_v_d      = 1'b1;
                    out_result_d = mul_result_i;
                    out_tag_d    = tag_r_q;
                    state_d      = (!fifo_empty || fifo_enq) ? S_ISSUE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, in-flight tag and output register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            tag_r_q      <= '0;
            out_v_q      <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            tag_r_q      <= tag_r_d;
            out_v_q      <= out_v_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign v_o      = out_v_q;
    assign result_o = out_result_q;
    assign tag_o    = out_tag_q;

endmodule

// File: tb/tb_bsg_imul_dispatch.sv
// Bench for bsg_imul_dispatch paired with a behavioural iterative multiplier.
// Directed requests push hand-computed {result, tag} into a scoreboard queue;
// a monitor process pops and compares on every v_o & yumi_i handshake.
`timescale 1ns/1ps
module tb_bsg_imul_dispatch;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          v_i = 1'b0;
    logic          ready_and_o;
    logic [1:0]    op_i = '0;
    logic [W-1:0]  opA_i = '0, opB_i = '0;
    logic [TW-1:0] tag_i = '0;
    logic          v_o;
    logic [W-1:0]  result_o;
    logic [TW-1:0] tag_o;
    logic          yumi_i;
    logic          mul_v_o, mul_ready_and_i;
    logic [W-1:0]  mul_opA_o, mul_opB_o;
    logic          mul_signed_opA_o, mul_signed_opB_o, mul_gets_high_part_o;
    logic          mul_v_i;
    logic [W-1:0]  mul_result_i;
    logic          mul_yumi_o;

    logic          yumi_en = 1'b1;
    int            mul_lat = 3;
    int            n_chk = 0;
    int            n_fail = 0;
    int            n_results = 0;
    int            mul_v_cnt = 0;
    logic [W+TW-1:0] sb_q[$];

    always #5 clk_i = ~clk_i;

    assign yumi_i = v_o & yumi_en;

    bsg_imul_dispatch #(.width_p(W), .tag_width_p(TW), .els_p(2)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .v_i(v_i), .ready_and_o(ready_and_o), .op_i(op_i),
        .opA_i(opA_i), .opB_i(opB_i), .tag_i(tag_i),
        .v_o(v_o), .result_o(result_o), .tag_o(tag_o), .yumi_i(yumi_i),
        .mul_v_o(mul_v_o), .mul_ready_and_i(mul_ready_and_i),
        .mul_opA_o(mul_opA_o), .mul_opB_o(mul_opB_o),
        .mul_signed_opA_o(mul_signed_opA_o), .mul_signed_opB_o(mul_signed_opB_o),
        .mul_gets_high_part_o(mul_gets_high_part_o),
        .mul_v_i(mul_v_i), .mul_result_i(mul_result_i), .mul_yumi_o(mul_yumi_o)
    );

    // Behavioural iterative multiplier: fixed latency, holds result until yumi.
    logic         busy;
    int           cnt;
    logic [W-1:0] mres;

    function automatic logic [W-1:0] mul_model(input logic [W-1:0] a, b,
                                               input logic sa, sb, hi);
        logic signed [2*W+1:0] ea, eb, p;
        ea = sa ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
        eb = sb ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
        p  = ea * eb;
        return hi ? p[2*W-1:W] : p[W-1:0];
    endfunction

    assign mul_ready_and_i = ~busy;
    assign mul_v_i         = busy && (cnt == 0);
    assign mul_result_i    = mres;

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy <= 1'b0;
            cnt  <= 0;
            mres <= '0;
        end else if (busy) begin
            if (cnt > 0) cnt <= cnt - 1;
            else if (mul_yumi_o) busy <= 1'b0;
        end else if (mul_v_o) begin
            busy <= 1'b1;
            cnt  <= mul_lat;
            mres <= mul_model(mul_opA_o, mul_opB_o, mul_signed_opA_o,
                              mul_signed_opB_o, mul_gets_high_part_o);
        end
    end

    always @(posedge clk_i) if (mul_v_o) mul_v_cnt <= mul_v_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold v_i until accepted, then record the expected response.
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input logic [W-1:0] exp);
        int i;
        op_i = op; opA_i = a; opB_i = b; tag_i = tag; v_i = 1'b1;
        for (i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (ready_and_o) break;
        end
        if (i == 300) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: tag %0d not accepted, ready_and_o=%0b required 1", tag, ready_and_o);
        end else begin
            @(posedge clk_i);
            sb_q.push_back({exp, tag});
        end
        #1 v_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            @(posedge clk_i); #2;
            if (sb_q.size() == 0 && !v_o && !busy) break;
        end
        if (i == 400) begin
            n_chk++; n_fail++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb_q.size());
        end
    endtask

    initial begin
        int base;
        int mv;

        // Scoreboard monitor: compares every consumed result, and checks that
        // a same-cycle pop + load leaves v_o asserted.
        fork
            begin
                logic hold_chk;
                logic [W+TW-1:0] exp;
                hold_chk = 1'b0;
                forever begin
                    @(negedge clk_i);
                    if (!reset_n_i) begin
                        hold_chk = 1'b0;
                    end else begin
                        if (hold_chk) begin
                            chk("v_o_after_pop_and_load", 64'(v_o), 64'd1);
                            hold_chk = 1'b0;
                        end
                        if (v_o && yumi_i) begin
                            if (sb_q.size() == 0) begin
                                n_chk++; n_fail++;
                                $display("FAIL unexpected_result: got %0h tag %0d, required none", result_o, tag_o);
                            end else begin
                                exp = sb_q.pop_front();
                                chk("result_tag", 64'({result_o, tag_o}), 64'(exp));
                                n_results++;
                            end
                            if (mul_yumi_o) hold_chk = 1'b1;
                        end
                    end
                end
            end
        join_none

        // Reset state
        #2;
        chk("rst_ready", 64'(ready_and_o), 64'd0);
        chk("rst_v_o", 64'(v_o), 64'd0);
        chk("rst_mul_v_o", 64'(mul_v_o), 64'd0);
        chk("rst_mul_yumi_o", 64'(mul_yumi_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_tag", 64'(tag_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        #1 chk("ready_after_rst", 64'(ready_and_o), 64'd1);
        @(posedge clk_i); #1;

        // Basic MUL, issue one cycle after accept, low half
        send(2'd0, 32'd7, 32'd6, 4'd3, 32'h0000002A);
        chk("t1_mul_v_o", 64'(mul_v_o), 64'd1);
        chk("t1_high", 64'(mul_gets_high_part_o), 64'd0);
        drain("t1");

        // High-part variants and their decode
        send(2'd1, 32'hFFFFFFFE, 32'd3, 4'd1, 32'hFFFFFFFF);
        chk("mulh_sa", 64'(mul_signed_opA_o), 64'd1);
        chk("mulh_sb", 64'(mul_signed_opB_o), 64'd1);
        chk("mulh_high", 64'(mul_gets_high_part_o), 64'd1);
        drain("mulh");
        send(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'hFFFFFFFE);
        chk("mulhu_sa", 64'(mul_signed_opA_o), 64'd0);
        chk("mulhu_sb", 64'(mul_signed_opB_o), 64'd0);
        drain("mulhu");
        send(2'd2, 32'hFFFFFFFF, 32'd2, 4'd4, 32'hFFFFFFFF);
        chk("mulhsu_sa", 64'(mul_signed_opA_o), 64'd1);
        chk("mulhsu_sb", 64'(mul_signed_opB_o), 64'd0);
        drain("mulhsu");

        // Back-pressure: three back-to-back requests with the consumer stalled
        base = n_results;
        yumi_en = 1'b0;
        send(2'd0, 32'd1, 32'd1, 4'd0, 32'd1);
        send(2'd0, 32'd2, 32'd3, 4'd1, 32'd6);
        send(2'd0, 32'd4, 32'd5, 4'd2, 32'd20);
        chk("bp_ready_drops", 64'(ready_and_o), 64'd0);
        repeat (20) @(posedge clk_i);
        #1 chk("bp_v_o_held", 64'(v_o), 64'd1);
        chk("bp_mul_result_held", 64'(mul_yumi_o), 64'd0);
        yumi_en = 1'b1;
        drain("bp");
        chk("bp_result_count", 64'(n_results - base), 64'd3);

        // Reset while an op waits on the multiplier
        yumi_en = 1'b0;
        send(2'd0, 32'd3, 32'd3, 4'd1, 32'd9);
        send(2'd0, 32'd4, 32'd4, 4'd2, 32'd16);
        repeat (15) @(posedge clk_i);
        #1 yumi_en = 1'b1;
        #1 chk("pre_rst_v_o", 64'(v_o), 64'd1);
        chk("pre_rst_mul_yumi", 64'(mul_yumi_o), 64'd1);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_v_o", 64'(v_o), 64'd0);
        chk("mid_rst_mul_v_o", 64'(mul_v_o), 64'd0);
        chk("mid_rst_mul_yumi", 64'(mul_yumi_o), 64'd0);
        chk("mid_rst_ready", 64'(ready_and_o), 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        base = n_results;
        send(2'd0, 32'd2, 32'd2, 4'd5, 32'd4);
        drain("post_rst");
        chk("post_rst_count", 64'(n_results - base), 64'd1);

        // Zero operand
        mv = mul_v_cnt;
        send(2'd0, 32'd0, 32'd5, 4'd9, 32'd0);
`ifdef BSG_IMUL_DISPATCH_ZERO_BYPASS_EN
        chk("zb_no_issue", 64'(mul_v_o), 64'd0);
        @(posedge clk_i); #1;
        chk("zb_v_o", 64'(v_o), 64'd1);
        drain("zb");
        chk("zb_mul_v_never", 64'(mul_v_cnt - mv), 64'd0);
`else
        chk("zero_issues", 64'(mul_v_o), 64'd1);
        drain("zero");
        chk("zero_mul_v_seen", 64'(mul_v_cnt - mv > 0), 64'd1);
`endif

        // Enqueue into a full FIFO alongside a dequeue; pop and load together
        base = n_results;
        yumi_en = 1'b0;
        send(2'd0, 32'd1, 32'd2, 4'd4, 32'd2);
        send(2'd0, 32'd3, 32'd3, 4'd5, 32'd9);
        send(2'd0, 32'd5, 32'd5, 4'd6, 32'd25);
        send(2'd0, 32'd7, 32'd7, 4'd7, 32'd49);
        repeat (15) @(posedge clk_i);
        #1 chk("full_ready_low", 64'(ready_and_o), 64'd0);
        chk("full_v_o", 64'(v_o), 64'd1);
        yumi_en = 1'b1;
        send(2'd0, 32'd9, 32'd9, 4'd8, 32'd81);
        drain("full");
        chk("full_result_count", 64'(n_results - base), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
